// File: rtl/divider_fp8_seq.sv
// rtl/divider_fp8_seq.sv - sequential FP8 (1/3/4, bias 3) divider with restoring quotient loop
module divider_fp8_seq #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       div_by_zero
);

    typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

    // Special-case classification: {is_special, div_by_zero, result}
    function automatic logic [9:0] classify(input logic [7:0] x, input logic [7:0] y);
        logic s, x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;
        s      = x[7] ^ y[7];
        x_nan  = (x[6:4] == 3'h7) && (x[3:0] != 4'h0);
        x_inf  = (x[6:4] == 3'h7) && (x[3:0] == 4'h0);
        x_zero = (x[6:0] == 7'h00);
        y_nan  = (y[6:4] == 3'h7) && (y[3:0] != 4'h0);
        y_inf  = (y[6:4] == 3'h7) && (y[3:0] == 4'h0);
        y_zero = (y[6:0] == 7'h00);
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
            classify = {1'b1, 1'b0, s, 3'h7, 4'hF};
        else if (x_inf)
            classify = {1'b1, 1'b0, s, 3'h7, 4'h0};
        else if (y_zero)
            classify = {1'b1, 1'b1, s, 3'h7, 4'h0};
        else if (x_zero || y_inf)
            classify = {1'b1, 1'b0, s, 7'h00};
        else
            classify = {2'b00, s, 7'h00};
    endfunction

    // Normalize an operand to a 5-bit significand with MSB set: {E[5:0] signed, M[4:0]}
    function automatic logic [10:0] norm_op(input logic [6:0] x);
        logic [4:0]        m;
        logic signed [5:0] e;
        if (x[6:4] != 3'h0) begin
            m = {1'b1, x[3:0]};
            e = $signed({3'b000, x[6:4]}) - 6'sd3;
        end else if (x[3]) begin
            m = {x[3:0], 1'b0};
            e = -6'sd3;
        end else if (x[2]) begin
            m = {x[2:0], 2'b00};
            e = -6'sd4;
        end else if (x[1]) begin
            m = {x[1:0], 3'b000};
            e = -6'sd5;
        end else if (x[0]) begin
            m = {x[0], 4'b0000};
            e = -6'sd6;
        end else begin
            m = 5'h00;
            e = 6'sd0;
        end
        norm_op = {e, m};
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic [4:0]        mb_q, mb_d;
    logic signed [5:0] ea_q, ea_d, eb_q, eb_d;
    logic [5:0]        rem_q, rem_d;
    logic [6:0]        quo_q, quo_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        result_q, result_d;
    logic              dbz_q, dbz_d;

    logic [9:0]        sp_in, sp_reg;
    logic [10:0]       na, nb;
    logic              ge;
    logic [5:0]        r_next;
    logic signed [5:0] ek_base, ek_rnd;
    logic [3:0]        mant_sel;
    logic              guard;
    logic [4:0]        mant_sum;
    logic [7:0]        fin_res;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

    // Datapath helpers: classification, normalization, one restoring step, rounding
    always_comb begin
        sp_in    = classify(a, b);
        sp_reg   = classify(a_q, b_q);
        na       = norm_op(a_q[6:0]);
        nb       = norm_op(b_q[6:0]);
        ge       = (rem_q >= {1'b0, mb_q});
        r_next   = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        mant_sel = 4'h0;
        guard    = 1'b0;
        ek_base  = 6'sd0;
        if (quo_q[6]) begin
            mant_sel = quo_q[5:2];
            guard    = quo_q[1];
            ek_base  = ea_q - eb_q + 6'sd3;
        end else begin
            mant_sel = quo_q[4:1];
            guard    = quo_q[0];
            ek_base  = ea_q - eb_q + 6'sd2;
        end
        mant_sum = {1'b0, mant_sel} + {4'h0, guard};
        ek_rnd   = mant_sum[4] ? (ek_base + 6'sd1) : ek_base;
        if (ek_rnd >= 6'sd7)
            fin_res = {a_q[7] ^ b_q[7], 3'h7, 4'h0};
        else if (ek_rnd <= 6'sd0)
            fin_res = {a_q[7] ^ b_q[7], 7'h00};
        else
            fin_res = {a_q[7] ^ b_q[7], ek_rnd[2:0], mant_sum[3:0]};
    end

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mb_d     = mb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                    if (EARLY_OUT && sp_in[9]) begin
                        result_d = sp_in[7:0];
                        dbz_d    = sp_in[8];
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                ea_d    = na[10:5];
                eb_d    = nb[10:5];
                mb_d    = nb[4:0];
                rem_d   = {1'b0, na[4:0]};
                quo_d   = 7'h00;
                cnt_d   = 3'd0;
                state_d = DIV;
            end
            DIV: begin
                quo_d = {quo_q[5:0], ge};
                rem_d = r_next << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6)
                    state_d = ROUND;
            end
            ROUND: begin
                if (sp_reg[9]) begin
                    result_d = sp_reg[7:0];
                    dbz_d    = sp_reg[8];
                end else begin
                    result_d = fin_res;
                    dbz_d    = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            mb_q     <= 5'h00;
            ea_q     <= 6'sd0;
            eb_q     <= 6'sd0;
            rem_q    <= 6'h00;
            quo_q    <= 7'h00;
            cnt_q    <= 3'd0;
            result_q <= 8'h00;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mb_q     <= mb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule
